// File: rtl/rkey_store_ctrl_if.sv
// Bundle between the AES key expander, cipher datapath, round-key RAMs and
// rkey_store_ctrl. master = expander/datapath/RAM side, slave = controller.
interface rkey_store_ctrl_if;
  logic         key_start;
  logic [1:0]   key_len;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic         rk_ready;
  logic         key_rdy;
  logic         rd_req;
  logic [3:0]   rd_round;
  logic         rkey_valid;
  logic [127:0] rkey;
  logic         rd_err;
  logic         ram_wr;
  logic [3:0]   ram_wr_addr;
  logic [63:0]  ram_wr_data_hi;
  logic [63:0]  ram_wr_data_lo;
  logic         ram_rd;
  logic [3:0]   ram_rd_addr;
  logic [63:0]  ram_rd_data_hi;
  logic [63:0]  ram_rd_data_lo;

  modport slave (
    input  key_start, key_len, rk_valid, rk_data,
    input  rd_req, rd_round, ram_rd_data_hi, ram_rd_data_lo,
    output rk_ready, key_rdy, rkey_valid, rkey, rd_err,
    output ram_wr, ram_wr_addr, ram_wr_data_hi, ram_wr_data_lo,
    output ram_rd, ram_rd_addr
  );

  modport master (
    output key_start, key_len, rk_valid, rk_data,
    output rd_req, rd_round, ram_rd_data_hi, ram_rd_data_lo,
    input  rk_ready, key_rdy, rkey_valid, rkey, rd_err,
    input  ram_wr, ram_wr_addr, ram_wr_data_hi, ram_wr_data_lo,
    input  ram_rd, ram_rd_addr
  );
endinterface

// File: rtl/rkey_store_ctrl.sv
// Round-key store controller: writes 11/13/15 round keys into hi/lo RAMs,
// then serves 2-cycle-latency reads. Ports: clk, rst, bus (slave modport).
module rkey_store_ctrl (
  input logic             clk,
  input logic             rst,
  rkey_store_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_e;

  state_e       state_q, state_d;
  logic [3:0]   nr_q, nr_d;
  logic [3:0]   wr_cnt_q, wr_cnt_d;
  logic [1:0]   vld_q, err_q;
  logic [127:0] rkey_q;
  logic         wr_fire, last_wr;
  logic         rd_acc, rd_rej;

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    logic [3:0] n;
    unique case (len)
      2'd0:    n = 4'd10;
      2'd1:    n = 4'd12;
      default: n = 4'd14;
    endcase
    return n;
  endfunction

  assign bus.key_rdy    = (state_q == READY);
  assign bus.rkey_valid = vld_q[1];
  assign bus.rd_err     = err_q[1];
  assign bus.rkey       = rkey_q;

  always_comb begin
    state_d  = state_q;
    nr_d     = nr_q;
    wr_cnt_d = wr_cnt_q;

    bus.rk_ready = (state_q == LOAD) & ~bus.key_start;
    wr_fire      = bus.rk_valid & bus.rk_ready;
    last_wr      = wr_fire & (wr_cnt_q == nr_q);

    bus.ram_wr         = wr_fire;
    bus.ram_wr_addr    = wr_cnt_q;
    bus.ram_wr_data_hi = bus.rk_data[127:64];
    bus.ram_wr_data_lo = bus.rk_data[63:0];

    rd_acc = bus.rd_req & bus.key_rdy
           & (bus.rd_round <= nr_q) & ~bus.key_start;
    rd_rej = bus.rd_req & ~rd_acc;

    bus.ram_rd      = rd_acc;
    bus.ram_rd_addr = bus.rd_round;

    if (bus.key_start) begin
      state_d  = LOAD;
      nr_d     = nr_of(bus.key_len);
      wr_cnt_d = 4'd0;
    end else if (last_wr) begin
      // counter parks on nr; no further writes leave READY
      state_d = READY;
    end else if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      nr_q     <= 4'd10;
      wr_cnt_q <= 4'd0;
      vld_q    <= 2'b00;
      err_q    <= 2'b00;
      rkey_q   <= '0;
    end else begin
      state_q  <= state_d;
      nr_q     <= nr_d;
      wr_cnt_q <= wr_cnt_d;
      vld_q    <= {vld_q[0], rd_acc};
      err_q    <= {err_q[0], rd_rej};
      // RAM output is valid the cycle after the accepted request
      if (vld_q[0]) begin
        rkey_q <= {bus.ram_rd_data_hi, bus.ram_rd_data_lo};
      end
    end
  end
endmodule
